// File: rtl/nibble_sub_seq_if.sv
// Bundles the operand request channel, the result channel and the shared
// 4-bit adder hookup of nibble_sub_seq.
//   slave  : the sequencer's view (drives in_ready, out_*, alu_a/b/cin/en).
//   master : the requester/consumer and the adder's view.
// Optional signed-overflow flag ovf exists only when NIBBLE_SUB_OVF_EN is defined.
interface nibble_sub_seq_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         alu_en;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic         alu_cin;
    logic [3:0]   alu_s;
    logic         alu_cout;
`ifdef NIBBLE_SUB_OVF_EN
    logic         ovf;

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready, alu_s, alu_cout,
        output in_ready, out_valid, result, carry_out, alu_en, alu_a, alu_b, alu_cin, ovf
    );
    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready, alu_s, alu_cout,
        input  in_ready, out_valid, result, carry_out, alu_en, alu_a, alu_b, alu_cin, ovf
    );
`else
    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready, alu_s, alu_cout,
        output in_ready, out_valid, result, carry_out, alu_en, alu_a, alu_b, alu_cin
    );
    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready, alu_s, alu_cout,
        input  in_ready, out_valid, result, carry_out, alu_en, alu_a, alu_b, alu_cin
    );
`endif
endinterface

// File: rtl/nibble_sub_seq.sv
// nibble_sub_seq: computes W-bit (W = 4*NIBBLES) a+b or a-b on a shared
// external 4-bit adder, one nibble per clock, LSB nibble first, carry chained.
// Subtraction is a + ~b + 1 (carry seeded with op_sub).
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   bus (slave modport)  : in_valid/in_ready/op_a/op_b/op_sub request,
//                          out_valid/out_ready/result/carry_out response,
//                          alu_en/alu_a/alu_b/alu_cin to adder, alu_s/alu_cout back
// Optional: define NIBBLE_SUB_OVF_EN to add bus.ovf (signed overflow, valid in DONE).
// Every output is a register loaded from its next-state value, so the adder
// operands for nibble idx are presented during the cycle that consumes them.
module nibble_sub_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input logic              clk,
    input logic              rst_n,
    nibble_sub_seq_if.slave  bus
);
    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [W-1:0]     r_a, w_a_nxt;
    logic [W-1:0]     r_b, w_b_nxt;
    logic [W-1:0]     r_res, w_res_nxt;
    logic             r_sub, w_sub_nxt;
    logic             r_carry, w_carry_nxt;

    logic             r_in_ready, w_in_ready_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [W-1:0]     r_result, w_result_nxt;
    logic             r_carry_out, w_carry_out_nxt;
    logic             r_alu_en, w_alu_en_nxt;
    logic [3:0]       r_alu_a, w_alu_a_nxt;
    logic [3:0]       r_alu_b, w_alu_b_nxt;
    logic             r_alu_cin, w_alu_cin_nxt;
`ifdef NIBBLE_SUB_OVF_EN
    logic             r_ovf, w_ovf_nxt;
    logic             w_msb_cin;
`endif

    // Next-state, datapath and registered-output values
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_res_nxt   = r_res;
        w_sub_nxt   = r_sub;
        w_carry_nxt = r_carry;

        case (r_state)
            IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_a_nxt     = bus.op_a;
                    w_b_nxt     = bus.op_b;
                    w_sub_nxt   = bus.op_sub;
                    w_carry_nxt = bus.op_sub;
                    w_res_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_res_nxt[{r_idx, 2'b00} +: 4] = bus.alu_s;
                w_carry_nxt = bus.alu_cout;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_in_ready_nxt  = (w_state_nxt == IDLE);
        w_out_valid_nxt = (w_state_nxt == DONE);
        w_alu_en_nxt    = (w_state_nxt == RUN);
        w_alu_a_nxt     = '0;
        w_alu_b_nxt     = '0;
        w_alu_cin_nxt   = 1'b0;
        w_result_nxt    = '0;
        w_carry_out_nxt = 1'b0;

        // Present the nibble the next RUN cycle will add
        if (w_state_nxt == RUN) begin
            w_alu_a_nxt   = w_a_nxt[{w_idx_nxt, 2'b00} +: 4];
            w_alu_b_nxt   = w_b_nxt[{w_idx_nxt, 2'b00} +: 4] ^ {4{w_sub_nxt}};
            w_alu_cin_nxt = w_carry_nxt;
        end

        // Subtraction reports borrow, i.e. the inverted final carry
        if (w_state_nxt == DONE) begin
            w_result_nxt    = w_res_nxt;
            w_carry_out_nxt = w_sub_nxt ? ~w_carry_nxt : w_carry_nxt;
        end

`ifdef NIBBLE_SUB_OVF_EN
        // Carry into the MSB recovered from s3 = a3 ^ b3' ^ c3
        w_msb_cin = r_alu_a[3] ^ r_alu_b[3] ^ bus.alu_s[3];
        w_ovf_nxt = 1'b0;
        if (w_state_nxt == DONE) begin
            w_ovf_nxt = (r_state == RUN) ? (w_msb_cin ^ bus.alu_cout) : r_ovf;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_alu_en    <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_cin   <= 1'b0;
`ifdef NIBBLE_SUB_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_res       <= w_res_nxt;
            r_sub       <= w_sub_nxt;
            r_carry     <= w_carry_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_result    <= w_result_nxt;
            r_carry_out <= w_carry_out_nxt;
            r_alu_en    <= w_alu_en_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_alu_cin   <= w_alu_cin_nxt;
`ifdef NIBBLE_SUB_OVF_EN
            r_ovf       <= w_ovf_nxt;
`endif
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.alu_en    = r_alu_en;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_cin   = r_alu_cin;
`ifdef NIBBLE_SUB_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Self-checking bench for nibble_sub_seq (NIBBLES=4) with a behavioural
// 4-bit adder stub and a result scoreboard.
module tb_nibble_sub_seq;
    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 16;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t q_exp[$];
    int   q_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_sub_seq_if #(.NIBBLES(NIB)) bus ();
    nibble_sub_seq #(.NIBBLES(NIB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Adder stub: s,cout = a + b + cin
    logic [4:0] w_sum;
    assign w_sum        = 5'(bus.alu_a) + 5'(bus.alu_b) + 5'(bus.alu_cin);
    assign bus.alu_s    = w_sum[3:0];
    assign bus.alu_cout = w_sum[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t        e;
        logic [W:0]  full;
        if (sub) begin
            e.res = a - b;
            e.co  = (a < b);
            e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        end else begin
            full  = {1'b0, a} + {1'b0, b};
            e.res = full[W-1:0];
            e.co  = full[W];
            e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        end
        return e;
    endfunction

    // Scoreboard and idle-value monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_pending", 32'(q_exp.size() != 0), 32'd1);
                if (q_exp.size() != 0) begin
                    e = q_exp.pop_front();
                    q_cyc.push_back(cyc);
                    chk("sb_result", 32'(bus.result), 32'(e.res));
                    chk("sb_carry_out", 32'(bus.carry_out), 32'(e.co));
`ifdef NIBBLE_SUB_OVF_EN
                    chk("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
                end
            end else if (!bus.out_valid) begin
                chk("idle_result", 32'(bus.result), 32'd0);
                chk("idle_carry_out", 32'(bus.carry_out), 32'd0);
`ifdef NIBBLE_SUB_OVF_EN
                chk("idle_ovf", 32'(bus.ovf), 32'd0);
`endif
            end
            if (!bus.alu_en) begin
                chk("alu_idle", 32'({bus.alu_a, bus.alu_b, bus.alu_cin}), 32'd0);
            end
        end
    end

    // Drive a request; returns just after its accept edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit push);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_sub   = sub;
        if (push) q_exp.push_back(model(a, b, sub));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Count cycles after accept until out_valid, and alu_en cycles on the way
    task automatic wait_out(output int lat, output int en);
        lat = -1;
        en  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.alu_en) en++;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_result"}, 32'(bus.result), 32'd0);
        chk({tag, "_carry_out"}, 32'(bus.carry_out), 32'd0);
        chk({tag, "_alu"}, 32'({bus.alu_en, bus.alu_a, bus.alu_b, bus.alu_cin}), 32'd0);
`ifdef NIBBLE_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
`endif
    endtask

    initial begin
        int lat;
        int en;
        int k;
        logic [W-1:0] b2b_a [3];
        logic [W-1:0] b2b_b [3];
        logic         b2b_s [3];

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;

        // Latency and adder ownership
        issue(16'h1234, 16'h0034, 1'b1, 1'b1);
        wait_out(lat, en);
        chk("sub1_latency", 32'(lat), 32'd5);
        chk("sub1_alu_en_cycles", 32'(en), 32'd4);
        @(negedge clk);
        chk("sub1_back_to_idle", 32'(bus.in_ready), 32'd1);

        issue(16'h0000, 16'h0001, 1'b1, 1'b1);
        wait_out(lat, en);
        chk("sub2_latency", 32'(lat), 32'd5);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        wait_out(lat, en);
        chk("add1_latency", 32'(lat), 32'd5);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        wait_out(lat, en);
        chk("add2_latency", 32'(lat), 32'd5);

        // Backpressure: result held, new request waits
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        issue(16'h0000, 16'h0001, 1'b1, 1'b1);
        wait_out(lat, en);
        chk("bp_latency", 32'(lat), 32'd5);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.op_a     = 16'h0F0F;
        bus.op_b     = 16'h00F1;
        bus.op_sub   = 1'b0;
        q_exp.push_back(model(16'h0F0F, 16'h00F1, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_result", 32'(bus.result), 32'hFFFF);
            chk("bp_hold_carry", 32'(bus.carry_out), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(lat, en);
        chk("bp_next_latency", 32'(lat), 32'd5);

        // Reset in the 2nd RUN cycle discards the operation
        issue(16'h4321, 16'h8765, 1'b0, 1'b0);
        chk("rst_run1_alu", 32'({bus.alu_en, bus.alu_a, bus.alu_b, bus.alu_cin}), 32'({1'b1, 4'h1, 4'h5, 1'b0}));
        @(posedge clk); #1;
        chk("rst_run2_alu", 32'({bus.alu_en, bus.alu_a, bus.alu_b}), 32'({1'b1, 4'h2, 4'h6}));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_held");
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(16'h8000, 16'h8000, 1'b1, 1'b1);
        wait_out(lat, en);
        chk("rst_after_latency", 32'(lat), 32'd5);

        // Back-to-back with in_valid and out_ready held high
        b2b_a = '{16'h0008, 16'h0004, 16'h0003};
        b2b_b = '{16'h0008, 16'h0004, 16'h0005};
        b2b_s = '{1'b1, 1'b1, 1'b0};
        @(negedge clk);
        q_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.op_a     = b2b_a[i];
            bus.op_b     = b2b_b[i];
            bus.op_sub   = b2b_s[i];
            q_exp.push_back(model(b2b_a[i], b2b_b[i], b2b_s[i]));
            k = 0;
            while (k < 20) begin
                @(negedge clk);
                if (bus.in_ready) break;
                k++;
            end
            chk("b2b_accept_wait", 32'(k < 20), 32'd1);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        k = 0;
        while (k < 40 && q_exp.size() != 0) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("sb_drained", 32'(q_exp.size()), 32'd0);
        chk("b2b_outputs", 32'(q_cyc.size()), 32'd3);
        if (q_cyc.size() == 3) begin
            chk("b2b_spacing_1", 32'(q_cyc[1] - q_cyc[0]), 32'd6);
            chk("b2b_spacing_2", 32'(q_cyc[2] - q_cyc[1]), 32'd6);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
